// File: rtl/asrm_mem_responder.sv
// asrm_mem_responder
// Memory-side responder for the ASRM CPU RAM port. Serves word accesses from
// an internal single-port RAM and a 16-word register window holding a
// free-running counter, a compare/interrupt unit and a GPIO output register.
// Read data is registered once, so it lands well inside the CPU's two-cycle
// access window without a wait signal.
//
// Register window (offset = addr[3:0]):
//   0 COUNT   free-running, wraps; write loads
//   1 GPIO    drives gpio_out
//   2 COMPARE match target for the counter
//   3 STATUS  bit0 flag (sticky, write-1-clear), bit1 irq_en
//   4..15     read 0, writes ignored

module asrm_mem_responder #(
    parameter int unsigned          wordsize   = 16,
    parameter int unsigned          depth_log2 = 8,
    parameter logic [wordsize-1:0]  mmio_base  = 16'hFFF0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic [wordsize-1:0] gpio_out,
    output logic                irq
);

    localparam int unsigned ram_words   = 1 << depth_log2;
    localparam logic [3:0]  off_count   = 4'd0;
    localparam logic [3:0]  off_gpio    = 4'd1;
    localparam logic [3:0]  off_compare = 4'd2;
    localparam logic [3:0]  off_status  = 4'd3;

    logic                  in_ram;
    logic                  in_mmio;
    logic [depth_log2-1:0] ram_idx;
    logic [3:0]            mmio_off;

    logic                  wr_ram;
    logic                  wr_count;
    logic                  wr_gpio;
    logic                  wr_compare;
    logic                  wr_status;

    logic [wordsize-1:0]   mem [ram_words];

    logic [wordsize-1:0]   count_q;
    logic [wordsize-1:0]   compare_q;
    logic [wordsize-1:0]   gpio_q;
    logic [wordsize-1:0]   data_out_q;
    logic                  flag_q;
    logic                  irq_en_q;

    logic [wordsize-1:0]   count_next;
    logic [wordsize-1:0]   compare_next;
    logic [wordsize-1:0]   gpio_next;
    logic                  flag_next;
    logic                  irq_en_next;
    logic                  match;
    logic [wordsize-1:0]   mmio_rd;
    logic [wordsize-1:0]   rd_data;

    // Address decode. Anything outside RAM and the register window is a hole.
    assign in_ram   = (addr[wordsize-1:depth_log2] == '0);
    assign in_mmio  = (addr[wordsize-1:4] == mmio_base[wordsize-1:4]);
    assign ram_idx  = addr[depth_log2-1:0];
    assign mmio_off = addr[3:0];

    // An edge seen while reset is low must not commit anything, including RAM.
    assign wr_ram     = write_en & reset & in_ram;
    assign wr_count   = write_en & reset & in_mmio & (mmio_off == off_count);
    assign wr_gpio    = write_en & reset & in_mmio & (mmio_off == off_gpio);
    assign wr_compare = write_en & reset & in_mmio & (mmio_off == off_compare);
    assign wr_status  = write_en & reset & in_mmio & (mmio_off == off_status);

    // Next-state for the register window; match uses the pre-write COMPARE and
    // a concurrent match beats a write-1-clear of the flag.
    always_comb begin
        count_next   = wr_count ? data_in : count_q + wordsize'(1);
        compare_next = wr_compare ? data_in : compare_q;
        gpio_next    = wr_gpio ? data_in : gpio_q;
        irq_en_next  = wr_status ? data_in[1] : irq_en_q;
        match        = (count_next == compare_q);
        flag_next    = flag_q;
        if (match) begin
            flag_next = 1'b1;
        end else if (wr_status && data_in[0]) begin
            flag_next = 1'b0;
        end
    end

    // Read mux, write-first: a write to the location being read returns the
    // value it will hold after this edge. COUNT otherwise reads pre-increment.
    always_comb begin
        mmio_rd = '0;
        case (mmio_off)
            off_count:   mmio_rd = wr_count ? data_in : count_q;
            off_gpio:    mmio_rd = gpio_next;
            off_compare: mmio_rd = compare_next;
            off_status:  mmio_rd = wr_status
                                   ? {{(wordsize-2){1'b0}}, irq_en_next, flag_next}
                                   : {{(wordsize-2){1'b0}}, irq_en_q, flag_q};
            default:     mmio_rd = '0;
        endcase

        rd_data = '0;
        if (in_ram) begin
            rd_data = wr_ram ? data_in : mem[ram_idx];
        end else if (in_mmio) begin
            rd_data = mmio_rd;
        end
    end

    // RAM array: no reset, contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[ram_idx] <= data_in;
        end
    end

    // Register window state and the registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            compare_q  <= '1;
            gpio_q     <= '0;
            flag_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            count_q    <= count_next;
            compare_q  <= compare_next;
            gpio_q     <= gpio_next;
            flag_q     <= flag_next;
            irq_en_q   <= irq_en_next;
            data_out_q <= rd_data;
        end
    end

    assign data_out = data_out_q;
    assign gpio_out = gpio_q;
    assign irq      = flag_q & irq_en_q;

endmodule

// File: tb/tb_asrm_mem_responder.sv
// Directed bench for asrm_mem_responder: RAM, register window, counter match
// and asynchronous reset behaviour against hand-computed values.

module tb_asrm_mem_responder;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        write_en = 1'b0;
    logic [15:0] addr     = 16'h0000;
    logic [15:0] data_in  = 16'h0000;
    logic [15:0] data_out;
    logic [15:0] gpio_out;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    asrm_mem_responder #(
        .wordsize   (16),
        .depth_log2 (8),
        .mmio_base  (16'hFFF0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .write_en (write_en),
        .data_out (data_out),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    // Apply one bus cycle and return 1 time unit after the rising edge.
    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we);
        addr     = a;
        data_in  = d;
        write_en = we;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL rst_data_out: got %h want %h", data_out, 16'h0000); end
        total++; if (gpio_out !== 16'h0000) begin bad++; $display("FAIL rst_gpio_out: got %h want %h", gpio_out, 16'h0000); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want %b", irq, 1'b0); end
        step(16'hFFF1, 16'h1111, 1'b1);
        total++; if (gpio_out !== 16'h0000) begin bad++; $display("FAIL rst_write_blocked: got %h want %h", gpio_out, 16'h0000); end
        reset = 1'b1;
        step(16'hFFF0, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL count_first: got %h want %h", data_out, 16'h0000); end
        step(16'hFFF0, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h0001) begin bad++; $display("FAIL count_second: got %h want %h", data_out, 16'h0001); end
        step(16'hFFF2, 16'h0000, 1'b0);
        total++; if (data_out !== 16'hFFFF) begin bad++; $display("FAIL compare_rst: got %h want %h", data_out, 16'hFFFF); end
    endtask

    task automatic test_ram_round_trip();
        step(16'h0005, 16'hBEEF, 1'b1);
        step(16'h0006, 16'h1111, 1'b1);
        step(16'h0005, 16'h0000, 1'b0);
        total++; if (data_out !== 16'hBEEF) begin bad++; $display("FAIL ram_rd5: got %h want %h", data_out, 16'hBEEF); end
        step(16'h0006, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h1111) begin bad++; $display("FAIL ram_rd6: got %h want %h", data_out, 16'h1111); end
    endtask

    task automatic test_write_first_hole();
        step(16'h0009, 16'h1234, 1'b1);
        total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL ram_write_first: got %h want %h", data_out, 16'h1234); end
        step(16'h0000, 16'h0F0F, 1'b1);
        step(16'h0100, 16'h7777, 1'b1);
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL hole_write_rd: got %h want %h", data_out, 16'h0000); end
        step(16'h0000, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h0F0F) begin bad++; $display("FAIL hole_no_alias: got %h want %h", data_out, 16'h0F0F); end
        step(16'h0100, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL hole_read: got %h want %h", data_out, 16'h0000); end
    endtask

    task automatic test_counter_wrap();
        step(16'hFFF2, 16'h0001, 1'b1);
        step(16'hFFF3, 16'h0003, 1'b1);
        total++; if (data_out !== 16'h0002) begin bad++; $display("FAIL status_wf: got %h want %h", data_out, 16'h0002); end
        step(16'hFFF0, 16'hFFFE, 1'b1);
        total++; if (data_out !== 16'hFFFE) begin bad++; $display("FAIL count_wf: got %h want %h", data_out, 16'hFFFE); end
        step(16'hFFF0, 16'h0000, 1'b0);
        total++; if (data_out !== 16'hFFFE) begin bad++; $display("FAIL count_rd0: got %h want %h", data_out, 16'hFFFE); end
        step(16'hFFF0, 16'h0000, 1'b0);
        total++; if (data_out !== 16'hFFFF) begin bad++; $display("FAIL count_rd1: got %h want %h", data_out, 16'hFFFF); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want %b", irq, 1'b0); end
        step(16'hFFF0, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL count_wrap: got %h want %h", data_out, 16'h0000); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_match: got %b want %b", irq, 1'b1); end
        step(16'hFFF0, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h0001) begin bad++; $display("FAIL count_rd3: got %h want %h", data_out, 16'h0001); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_sticky: got %b want %b", irq, 1'b1); end
    endtask

    task automatic test_set_wins();
        step(16'hFFF2, 16'h0200, 1'b1);
        step(16'hFFF3, 16'h0003, 1'b1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL flag_clear: got %b want %b", irq, 1'b0); end
        step(16'hFFF0, 16'h01FF, 1'b1);
        step(16'hFFF3, 16'h0003, 1'b1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL set_wins_irq: got %b want %b", irq, 1'b1); end
        total++; if (data_out !== 16'h0003) begin bad++; $display("FAIL set_wins_status: got %h want %h", data_out, 16'h0003); end
        step(16'hFFF3, 16'h0003, 1'b1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL later_clear_irq: got %b want %b", irq, 1'b0); end
        total++; if (data_out !== 16'h0002) begin bad++; $display("FAIL later_clear_status: got %h want %h", data_out, 16'h0002); end
        step(16'hFFF3, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h0002) begin bad++; $display("FAIL status_rd: got %h want %h", data_out, 16'h0002); end
        step(16'hFFF0, 16'h02FE, 1'b1);
        step(16'hFFF2, 16'h02FF, 1'b1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL compare_old_used: got %b want %b", irq, 1'b0); end
        total++; if (data_out !== 16'h02FF) begin bad++; $display("FAIL compare_wf: got %h want %h", data_out, 16'h02FF); end
    endtask

    task automatic test_gpio();
        step(16'hFFF1, 16'hA5A5, 1'b1);
        total++; if (gpio_out !== 16'hA5A5) begin bad++; $display("FAIL gpio_out: got %h want %h", gpio_out, 16'hA5A5); end
        total++; if (data_out !== 16'hA5A5) begin bad++; $display("FAIL gpio_wf: got %h want %h", data_out, 16'hA5A5); end
        step(16'hFFF1, 16'h0000, 1'b0);
        total++; if (data_out !== 16'hA5A5) begin bad++; $display("FAIL gpio_readback: got %h want %h", data_out, 16'hA5A5); end
        step(16'hFFF7, 16'h1234, 1'b1);
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL off7_write_rd: got %h want %h", data_out, 16'h0000); end
        total++; if (gpio_out !== 16'hA5A5) begin bad++; $display("FAIL off7_no_gpio: got %h want %h", gpio_out, 16'hA5A5); end
        step(16'hFFF7, 16'h0000, 1'b0);
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL off7_read: got %h want %h", data_out, 16'h0000); end
    endtask

    task automatic test_async_reset();
        step(16'hFFF2, 16'h0500, 1'b1);
        step(16'hFFF0, 16'h04FF, 1'b1);
        step(16'hFFF0, 16'h0000, 1'b0);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b want %b", irq, 1'b1); end
        step(16'h0020, 16'hCAFE, 1'b1);
        step(16'h0020, 16'h0000, 1'b0);
        total++; if (data_out !== 16'hCAFE) begin bad++; $display("FAIL pre_reset_ram: got %h want %h", data_out, 16'hCAFE); end
        addr     = 16'hFFF1;
        data_in  = 16'h5A5A;
        write_en = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        total++; if (gpio_out !== 16'h0000) begin bad++; $display("FAIL async_gpio: got %h want %h", gpio_out, 16'h0000); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_irq: got %b want %b", irq, 1'b0); end
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL async_data_out: got %h want %h", data_out, 16'h0000); end
        write_en = 1'b0;
        addr     = 16'h0020;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (data_out !== 16'hCAFE) begin bad++; $display("FAIL ram_survives: got %h want %h", data_out, 16'hCAFE); end
        total++; if (gpio_out !== 16'h0000) begin bad++; $display("FAIL gpio_after: got %h want %h", gpio_out, 16'h0000); end
    endtask

    initial begin
        test_reset();
        test_ram_round_trip();
        test_write_first_hole();
        test_counter_wrap();
        test_set_wins();
        test_gpio();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/asrm_mem_responder.md
# asrm_mem_responder

Memory-side responder for the ASRM CPU RAM port. It decodes the CPU's `addr`/`write_en`/data bus and serves word accesses from an internal single-port RAM. A memory-mapped register window at the top of the address space holds a free-running cycle counter, a compare/interrupt unit and a GPIO output register. It sits between the CPU and the board pins, and returns read data within the CPU's fixed two-cycle access window with no wait signal.

## Interface
- `wordsize`, 16, data and address width.
- `depth_log2`, 8, log2 of the RAM depth in words; RAM occupies addresses 0 .. 2^depth_log2-1.
- `mmio_base`, 16'hFFF0, base of the 16-word register window; must be 16-aligned and at or above 2^depth_log2.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `addr` input wordsize: word address from the CPU.
- `data_in` input wordsize: write data from the CPU.
- `write_en` input 1: write strobe from the CPU.
- `data_out` output wordsize: registered read data to the CPU.
- `gpio_out` output wordsize: GPIO output register.
- `irq` output 1: compare interrupt, equal to `flag & irq_en`.

## Operation
- Address decode:
  - RAM region: `addr < 2^depth_log2`.
  - MMIO region: `addr[wordsize-1:4] == mmio_base[wordsize-1:4]`.
  - Hole: everything else. Hole reads return 0; hole writes are ignored.
- RAM: index `addr[depth_log2-1:0]`. Contents are not reset.
- MMIO offsets (`addr[3:0]`):
  - 0 COUNT: read/write. Increments by 1 every cycle and wraps from all-ones to 0. A write loads `data_in`.
  - 1 GPIO: read/write. Drives `gpio_out`.
  - 2 COMPARE: read/write.
  - 3 STATUS: bit0 `flag` (sticky; write 1 clears, write 0 has no effect), bit1 `irq_en` (read/write). Other bits read 0.
  - 4..15: read 0, writes ignored.
- Compare match: `count_next` is the written value on a COUNT write, otherwise `count+1`. `flag` sets at the edge where `count_next == compare`. COMPARE is compared at its current (pre-write) value.
- Simultaneous events:
  - Flag set and STATUS clear at the same edge: set wins, and `flag` stays 1.
  - COMPARE write and match at the same edge: match uses the old COMPARE.
- Writes:
  - Commit at every rising edge with `write_en=1`. Repeated strobes with unchanged addr/data are idempotent.
  - `write_en` is honoured regardless of how long it is held. The CPU may hold it for multiple cycles.
- Reads:
  - `data_out` is registered every cycle from the current `addr`.
  - A read in the same cycle as a write to the same location returns the new value (write-first). This holds for both RAM and MMIO.
- Reset (async assert): state is cleared immediately and the RAM array is untouched. Reset values:
  - `data_out`=0, `gpio_out`=0, `irq`=0
  - COUNT=0, COMPARE=all-ones
  - `flag`=0, `irq_en`=0
- Reset deassertion: the first edge after release increments COUNT to 1. A reset asserted mid-access aborts that write.

## Timing
- Read latency is 1 cycle: with `addr` stable before edge N, `data_out` holds the word from edge N. The CPU holds `addr` for 2 cycles and samples on the second, so the window is met with 1 cycle of margin.
- Write latency: the value is visible at the next edge's read.
- `irq` is combinational from registered `flag`/`irq_en`, with no extra delay: it rises in the cycle after the matching edge.
- COUNT reads return the value at the sampling edge, i.e. the pre-increment value.
- No combinational path from `addr` or `data_in` to any output.

## Test plan
- **RAM round trip:** write 16'hBEEF to addr 5, then read addr 5 → `data_out`=16'hBEEF 1 cycle after `addr` is applied.
- **Write-first and hole:**
  - Write 16'h1234 to addr 9 and read addr 9 in the same cycle → next-cycle `data_out`=16'h1234.
  - Read addr 16'h0100 (hole) → 0.
- **Counter wrap and match:**
  - Write COUNT=16'hFFFE, COMPARE=16'h0001, STATUS=2 (`irq_en`) → COUNT reads FFFF, 0000, 0001.
  - `flag`/`irq` rise at the edge where COUNT becomes 1.
- **Set-wins:** write STATUS=3 on the edge where the match occurs → `flag` remains 1 and `irq` stays high. A later STATUS=3 write with no match clears `flag` to 0.
- **GPIO:**
  - Write 16'hA5A5 to 16'hFFF1 → `gpio_out`=16'hA5A5 next cycle and readback matches.
  - Offset 7 reads 0.
- **Async reset mid-write:** pulse `reset` low between edges while `write_en` is held to GPIO → `gpio_out`, `irq`, `data_out` go to 0 immediately, and a RAM word written before reset still reads back unchanged.
